// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receive FIFO: head entry, pop handshake and status.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]        rx_data;
  logic                        rx_perr;
  logic                        rx_ferr;
  logic                        rx_valid;
  logic                        rx_ack;
  logic                        overrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_valid, overrun, fifo_count,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_valid, overrun, fifo_count,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits, 16x
// oversampling with 3-sample majority) feeding a first-word-fall-through FIFO with error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_rx,
  uart_rx_fifo_if.master io_bus
);

  localparam int DIV     = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_BITS + 2;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [DIV_W-1:0]       r_divCnt;
  logic [3:0]             r_tickIdx;
  logic [1:0]             r_samp;
  logic [DATA_BITS-1:0]   r_shift;
  logic [3:0]             r_bitCnt;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_break;
  logic                   r_overrun;
  logic [ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_count;

  logic                   w_tick;
  logic                   w_decide;
  logic                   w_bitEnd;
  logic                   w_maj;
  logic                   w_startDet;
  logic                   w_frameDone;
  logic                   w_parityExp;
  logic                   w_ferrNow;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_valid;
  logic [ENTRY_W-1:0]     w_head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // The start-detect cycle itself counts as tick 0 of the start bit, so the index resumes at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_divCnt  <= '0;
      r_tickIdx <= '0;
    end else if (w_startDet) begin
      r_divCnt  <= '0;
      r_tickIdx <= 4'd1;
    end else if (w_tick) begin
      r_divCnt  <= '0;
      r_tickIdx <= r_tickIdx + 4'd1;
    end else begin
      r_divCnt  <= r_divCnt + 1'b1;
    end
  end

  assign w_tick      = (r_divCnt == DIV_W'(DIV - 1));
  assign w_decide    = w_tick && (r_tickIdx == 4'd9);
  assign w_bitEnd    = w_tick && (r_tickIdx == 4'd15);
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
  assign w_parityExp = (^r_shift) ^ (PARITY == 1);
  assign w_ferrNow   = r_ferr | ~w_maj;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_startDet  = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_break && !r_sync2) begin
          w_stateNext = S_START;
          w_startDet  = 1'b1;
        end
      end
      S_START: begin
        if (w_decide && w_maj) begin
          w_stateNext = S_IDLE;
        end else if (w_bitEnd) begin
          w_stateNext = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bitEnd && (r_bitCnt == 4'(DATA_BITS))) begin
          w_stateNext = (PARITY != 0) ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = S_STOP1;
        end
      end
      S_STOP1: begin
        if (STOP_BITS == 1) begin
          if (w_decide) begin
            w_frameDone = 1'b1;
            w_stateNext = S_IDLE;
          end
        end else if (w_bitEnd) begin
          w_stateNext = S_STOP2;
        end
      end
      S_STOP2: begin
        if (w_decide) begin
          w_frameDone = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // A break (all-zero data, bad stop, line still low) blocks re-arming until the line idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp   <= 2'b00;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_break  <= 1'b0;
    end else begin
      if (w_tick && (r_tickIdx == 4'd7)) r_samp[0] <= r_sync2;
      if (w_tick && (r_tickIdx == 4'd8)) r_samp[1] <= r_sync2;
      if (w_startDet) begin
        r_bitCnt <= '0;
        r_perr   <= 1'b0;
        r_ferr   <= 1'b0;
      end else if (w_decide) begin
        case (r_state)
          S_DATA: begin
            r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_bitCnt <= r_bitCnt + 4'd1;
          end
          S_PARITY:         r_perr <= (w_maj != w_parityExp);
          S_STOP1, S_STOP2: r_ferr <= w_ferrNow;
          default:          ;
        endcase
      end
      if (w_frameDone && w_ferrNow && (r_shift == '0) && !r_sync2) begin
        r_break <= 1'b1;
      end else if (r_sync2) begin
        r_break <= 1'b0;
      end
    end
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = io_bus.rx_ack && w_valid;
  assign w_push  = w_frameDone && ((r_count < DEPTH_C) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {r_shift, r_perr, w_ferrNow};
    end
  end

  // A push into a full FIFO only happens alongside a pop, so the overwritten slot is the departing head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_frameDone && !w_push;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head            = r_mem[r_rdPtr];
  assign io_bus.rx_valid   = w_valid;
  assign io_bus.rx_data    = w_valid ? w_head[ENTRY_W-1:2] : '0;
  assign io_bus.rx_perr    = w_valid & w_head[1];
  assign io_bus.rx_ferr    = w_valid & w_head[0];
  assign io_bus.overrun    = r_overrun;
  assign io_bus.fifo_count = r_count;

endmodule
